// File: rtl/trc_stack.sv
// LIFO save/restore stack for the $t0..$t7 register frame.
// Push saves the current frame on a call; Pop restores the most recent frame with a one-cycle write strobe.
module trc_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned FW    = 256,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Push,
    input  logic          Pop,
    input  logic          ClrErr,
    input  logic [FW-1:0] tRegistersIn,
    output logic [FW-1:0] tRegistersOut,
    output logic          TRCWrite,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Empty,
    output logic          Overflow,
    output logic          Underflow,
    output logic          Collision
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RESTORE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [FW-1:0]   out_q, out_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            col_q, col_d;

    logic [FW-1:0]   mem [DEPTH];

    logic            full_c;
    logic            empty_c;
    logic            pop_ok_c;
    logic            push_ok_c;
    logic [AW-1:0]   wr_idx_c;
    logic [AW-1:0]   rd_idx_c;

    always_comb begin
        full_c    = (count_q == CW'(DEPTH));
        empty_c   = (count_q == '0);
        pop_ok_c  = Pop && !empty_c;
        // A Push coinciding with a Pop is always dropped
        push_ok_c = Push && !Pop && !full_c;
        wr_idx_c  = AW'(count_q);
        rd_idx_c  = AW'(count_q - CW'(1));
    end

    // Next-state, counter, restored frame and sticky error flags
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        out_d   = out_q;
        ovf_d   = ovf_q & ~ClrErr;
        unf_d   = unf_q & ~ClrErr;
        col_d   = col_q & ~ClrErr;

        unique case (state_q)
            S_IDLE:    state_d = pop_ok_c ? S_RESTORE : S_IDLE;
            S_RESTORE: state_d = pop_ok_c ? S_RESTORE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (pop_ok_c) begin
            out_d   = mem[rd_idx_c];
            count_d = count_q - CW'(1);
        end else if (push_ok_c) begin
            count_d = count_q + CW'(1);
        end

        // New error events win over a simultaneous clear
        if (Push && !Pop && full_c) ovf_d = 1'b1;
        if (Pop && empty_c)         unf_d = 1'b1;
        if (Push && Pop)            col_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            col_q   <= col_d;
        end
    end

    // Frame storage carries no reset; validity is tracked by count_q
    always_ff @(posedge Clk) begin
        if (push_ok_c) begin
            mem[wr_idx_c] <= tRegistersIn;
        end
    end

    assign tRegistersOut = out_q;
    assign TRCWrite      = (state_q == S_RESTORE);
    assign Count         = count_q;
    assign Full          = full_c;
    assign Empty         = empty_c;
    assign Overflow      = ovf_q;
    assign Underflow     = unf_q;
    assign Collision     = col_q;

endmodule

// File: tb/tb_trc_stack.sv
// Randomized bench for trc_stack against a queue-based LIFO reference model.
module tb_trc_stack;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FW    = 256;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          Clk;
    logic          Rst_n;
    logic          Push;
    logic          Pop;
    logic          ClrErr;
    logic [FW-1:0] tRegistersIn;
    logic [FW-1:0] tRegistersOut;
    logic          TRCWrite;
    logic [CW-1:0] Count;
    logic          Full;
    logic          Empty;
    logic          Overflow;
    logic          Underflow;
    logic          Collision;

    trc_stack #(.DEPTH(DEPTH), .FW(FW)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Push          (Push),
        .Pop           (Pop),
        .ClrErr        (ClrErr),
        .tRegistersIn  (tRegistersIn),
        .tRegistersOut (tRegistersOut),
        .TRCWrite      (TRCWrite),
        .Count         (Count),
        .Full          (Full),
        .Empty         (Empty),
        .Overflow      (Overflow),
        .Underflow     (Underflow),
        .Collision     (Collision)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [FW-1:0] stk [$];
    logic [FW-1:0] m_out;
    logic          m_wr;
    logic          m_ovf, m_unf, m_col;

    logic [FW-1:0] pat_a, pat_b, pat_c, pat_d;
    logic [FW-1:0] frames [5];

    task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".count"},     FW'(Count),       FW'(stk.size()));
        check({ctx, ".full"},      FW'(Full),        FW'(stk.size() == DEPTH));
        check({ctx, ".empty"},     FW'(Empty),       FW'(stk.size() == 0));
        check({ctx, ".trcwrite"},  FW'(TRCWrite),    FW'(m_wr));
        check({ctx, ".out"},       tRegistersOut,    m_out);
        check({ctx, ".overflow"},  FW'(Overflow),    FW'(m_ovf));
        check({ctx, ".underflow"}, FW'(Underflow),   FW'(m_unf));
        check({ctx, ".collision"}, FW'(Collision),   FW'(m_col));
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic step(input logic push, input logic pop, input logic clr,
                        input logic [FW-1:0] din, input string ctx);
        int sz;
        Push = push; Pop = pop; ClrErr = clr; tRegistersIn = din;
        sz = stk.size();
        m_wr = 1'b0;
        if (pop && sz > 0) begin
            m_out = stk.pop_back();
            m_wr  = 1'b1;
        end else if (push && !pop && sz < DEPTH) begin
            stk.push_back(din);
        end
        if (clr) begin
            m_ovf = 1'b0; m_unf = 1'b0; m_col = 1'b0;
        end
        if (push && !pop && sz == DEPTH) m_ovf = 1'b1;
        if (pop && sz == 0)              m_unf = 1'b1;
        if (push && pop)                 m_col = 1'b1;
        @(posedge Clk);
        #1;
        Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0;
        check_all(ctx);
    endtask

    task automatic model_reset();
        stk.delete();
        m_out = '0; m_wr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_col = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; Push = 1'b0; Pop = 1'b0; ClrErr = 1'b0; tRegistersIn = '0;
        model_reset();
        pat_a = {32{8'h11}};
        pat_b = {32{8'h22}};
        pat_c = {32{8'hC3}};
        pat_d = {32{8'hD4}};
        #12;
        check_all("reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // Two pushes, two pops: B then A
        step(1, 0, 0, pat_a, "pushA");
        step(1, 0, 0, pat_b, "pushB");
        check("count_two", FW'(Count), FW'(2));
        step(0, 1, 0, '0, "pop1");
        check("pop1_val", tRegistersOut, pat_b);
        check("pop1_strobe", FW'(TRCWrite), FW'(1));
        step(0, 1, 0, '0, "pop2");
        check("pop2_val", tRegistersOut, pat_a);
        step(0, 0, 0, '0, "idle_after_pops");
        check("strobe_ends", FW'(TRCWrite), FW'(0));
        check("empty_end", FW'(Empty), FW'(1));

        // Overflow: fifth push is lost
        for (int i = 0; i < 5; i++) begin
            frames[i] = rand_frame();
            step(1, 0, 0, frames[i], "fill");
        end
        check("full_flag", FW'(Full), FW'(1));
        check("ovf_flag", FW'(Overflow), FW'(1));
        for (int i = 3; i >= 0; i--) begin
            step(0, 1, 0, '0, "drain");
            check("drain_val", tRegistersOut, frames[i]);
        end
        step(0, 0, 1, '0, "clr_ovf");

        // Underflow, and error event beats a simultaneous clear
        step(0, 1, 0, '0, "pop_empty");
        check("unf_out_held", tRegistersOut, frames[0]);
        step(0, 1, 1, '0, "clr_vs_unf");
        check("unf_wins", FW'(Underflow), FW'(1));
        step(0, 0, 1, '0, "clr_unf");

        // Collision: pop wins, push dropped
        step(1, 0, 0, pat_c, "pushC");
        step(1, 1, 0, pat_d, "collide");
        check("col_val", tRegistersOut, pat_c);
        check("col_flag", FW'(Collision), FW'(1));
        step(0, 1, 0, '0, "d_not_stored");
        check("d_not_stored_unf", FW'(Underflow), FW'(1));
        step(0, 0, 1, '0, "clr_all");

        // Reset in the middle of a restore strobe
        step(1, 0, 0, pat_a, "pre_rst_push");
        step(0, 1, 0, '0, "pre_rst_pop");
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        step(0, 1, 0, '0, "post_rst_pop");
        check("post_rst_unf", FW'(Underflow), FW'(1));
        step(0, 0, 1, '0, "post_rst_clr");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic pu, po, cl;
            r  = $urandom_range(0, 99);
            pu = (r < 45);
            po = (r >= 35 && r < 80);
            cl = ($urandom_range(0, 15) == 0);
            step(pu, po, cl, rand_frame(), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/trc_stack.md
TRC_STACK -- requirements
Module: trc_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of saved t-register frames (power of 2, 2..16).
REQ-002 SHALL have parameter FW, default 256, meaning the frame width in bits ($t0..$t7 concatenated, $t0 in the MSBs).
REQ-003 SHALL have port Clk  in  1  single system clock; all state changes on posedge.
REQ-004 SHALL have port Rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port Push  in  1  save request (call); samples tRegistersIn.
REQ-006 SHALL have port Pop  in  1  restore request (return).
REQ-007 SHALL have port ClrErr  in  1  clears sticky error flags.
REQ-008 SHALL have port tRegistersIn  in  FW  current $t0..$t7 from the register file.
REQ-009 SHALL have port tRegistersOut  out  FW  restored frame to the register file, registered.
REQ-010 SHALL have port TRCWrite  out  1  one-cycle restore strobe to the register file, registered.
REQ-011 SHALL have port Count  out  log2(DEPTH)+1  number of frames held.
REQ-012 SHALL have port Full, Empty  out  1 each  Count==DEPTH / Count==0.
REQ-013 SHALL have port Overflow, Underflow, Collision  out  1 each  sticky error flags.

Function
REQ-014 SHALL store frames in a LIFO array indexed by Count; array contents need no reset.
REQ-015 Push alone, not Full: SHALL write tRegistersIn into entry[Count] at posedge and increment Count.
REQ-016 Pop alone, not Empty: SHALL load entry[Count-1] into tRegistersOut and decrement Count at posedge, and assert TRCWrite for exactly the following cycle.
REQ-017 Restore latency SHALL be 1 cycle from Pop sample to TRCWrite=1; the register file captures on the next posedge.
REQ-018 TRCWrite SHALL be 0 in every cycle not directly following an accepted Pop; back-to-back Pops SHALL give back-to-back strobes with successive frames.
REQ-019 tRegistersOut SHALL hold its last value when no Pop is accepted.
REQ-020 Push while Full: SHALL be dropped (no write, Count unchanged) and SHALL set Overflow.
REQ-021 Pop while Empty: SHALL be dropped (no strobe, tRegistersOut unchanged) and SHALL set Underflow.
REQ-022 Push and Pop in the same cycle: SHALL perform the Pop per REQ-016/021, drop the Push, and set Collision.
REQ-023 ClrErr SHALL clear all three sticky flags at posedge; a new error event in the same cycle SHALL win (flag ends set).
REQ-024 Count SHALL never wrap; Full and Empty SHALL be decoded combinationally from Count.
REQ-025 Control SHALL be a two-state FSM: IDLE (TRCWrite=0) and RESTORE (TRCWrite=1); IDLE->RESTORE on accepted Pop; RESTORE->RESTORE on accepted Pop; RESTORE->IDLE otherwise.

Reset
REQ-026 Rst_n=0 SHALL immediately force Count=0, FSM=IDLE, TRCWrite=0, tRegistersOut=0, and all flags=0, without waiting for Clk.
REQ-027 Reset during RESTORE SHALL truncate the strobe at once; no register-file write SHALL occur after Rst_n falls.
REQ-028 First Push/Pop SHALL be sampled at the first posedge with Rst_n=1.

Verification
REQ-029 Push A=0x11..11 then B=0x22..22, Pop, Pop -> TRCWrite one cycle each, tRegistersOut=B then A, Count 2->1->0, Empty=1.
REQ-030 Push 5 frames with DEPTH=4 -> Count=4, Full=1, Overflow=1; 4 Pops return frames 4,3,2,1 (5th lost).
REQ-031 Pop when Empty -> TRCWrite stays 0, Underflow=1, tRegistersOut unchanged; ClrErr with a simultaneous empty Pop -> Underflow remains 1.
REQ-032 Count=1 holding C, Push D and Pop same cycle -> strobe with C, Count=0, Collision=1, D not stored.
REQ-033 Pop accepted, Rst_n low mid-strobe cycle -> TRCWrite falls asynchronously, Count=0, outputs 0; next Pop gives Underflow.
